// File: rtl/sm4_key_sched_multi.sv
// SM4 key expansion: ROUNDS_PER_CYCLE rounds per clock, results stored in
// NUM_SLOTS key contexts, read back one round key per request.
module sm4_key_sched_multi #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned NUM_SLOTS        = 2,
  localparam int unsigned SLOT_W          = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_in,
  input  logic                 key_valid_in,
  output logic                 key_ready_out,
  input  logic [127:0]         key_in,
  input  logic [SLOT_W-1:0]    key_slot_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [SLOT_W-1:0]    done_slot_out,
  output logic [NUM_SLOTS-1:0] slot_valid_out,
  input  logic                 rd_en_in,
  input  logic [SLOT_W-1:0]    rd_slot_in,
  input  logic [4:0]           rd_round_in,
  input  logic                 rd_decrypt_in,
  output logic                 rd_valid_out,
  output logic                 rd_miss_out,
  output logic [31:0]          rd_key_out
);

  localparam int unsigned     R        = ROUNDS_PER_CYCLE;
  localparam int unsigned     STEPS    = 32 / R;
  localparam logic [4:0]      LAST_CNT = 5'(STEPS - 1);
  localparam logic [SLOT_W:0] SLOT_LIM = (SLOT_W + 1)'(NUM_SLOTS);
  localparam logic [127:0]    FK       = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  // SM4 S-box; byte k sits at bits [(255-k)*8 +: 8], and 255-k == ~k
  localparam logic [2047:0] SBOX_TBL = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sm4_sbox(input logic [7:0] a);
    return SBOX_TBL[{~a, 3'b000} +: 8];
  endfunction

  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [127:0]           k_q, k_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [NUM_SLOTS-1:0]   slot_valid_q, slot_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [SLOT_W-1:0]      done_slot_q, done_slot_d;
  logic                   rd_valid_q, rd_miss_q;
  logic [31:0]            rd_key_q;
  logic [31:0]            mem_q [NUM_SLOTS][32];

  logic                   accept_c, last_c, wr_c, rd_hit_c;
  logic [4:0]             base_idx_c, rd_idx_c;
  logic [R:0][127:0]      win_c;
  logic [R-1:0][31:0]     rk_c;

  assign key_ready_out = (state_q == IDLE) & enable_in;
  assign accept_c      = key_valid_in & key_ready_out & ({1'b0, key_slot_in} < SLOT_LIM);
  assign last_c        = (cnt_q == LAST_CNT);
  assign wr_c          = (state_q == EXPAND) & enable_in;
  assign base_idx_c    = 5'(cnt_q * 5'(R));

  // Unrolled key rounds; the K window slides by one word per round
  assign win_c[0] = k_q;
  for (genvar j = 0; j < R; j++) begin : g_round
    logic [4:0]  idx;
    logic [7:0]  ck0;
    logic [31:0] x, b, t;
    assign idx = base_idx_c + 5'(j);
    assign ck0 = 8'({3'b000, idx} * 8'd28);
    assign x   = win_c[j][95:64] ^ win_c[j][63:32] ^ win_c[j][31:0]
               ^ {ck0, ck0 + 8'd7, ck0 + 8'd14, ck0 + 8'd21};
    for (genvar s = 0; s < 4; s++) begin : g_sbox
      assign b[8*s +: 8] = sm4_sbox(x[8*s +: 8]);
    end
    assign t            = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    assign rk_c[j]      = win_c[j][127:96] ^ t;
    assign win_c[j+1]   = {win_c[j][95:0], rk_c[j]};
  end

  // Next-state and control: accept, expand, complete or abort
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    done_slot_d  = done_slot_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d                   = EXPAND;
          k_d                       = key_in ^ FK;
          cnt_d                     = '0;
          slot_d                    = key_slot_in;
          slot_valid_d[key_slot_in] = 1'b0;
          busy_d                    = 1'b1;
        end
      end
      EXPAND: begin
        if (!enable_in) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          k_d   = win_c[R];
          cnt_d = cnt_q + 5'd1;
          if (last_c) begin
            state_d              = IDLE;
            busy_d               = 1'b0;
            done_d               = 1'b1;
            done_slot_d          = slot_q;
            slot_valid_d[slot_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and key-window registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      cnt_q        <= '0;
      slot_q       <= '0;
      slot_valid_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_slot_q  <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_slot_q  <= done_slot_d;
    end
  end

  // Round-key storage write, R words per expansion cycle
  always_ff @(posedge clk) begin
    if (wr_c) begin
      for (int j = 0; j < R; j++) begin
        mem_q[slot_q][5'(base_idx_c + 5'(j))] <= rk_c[j];
      end
    end
  end

  assign rd_idx_c = rd_decrypt_in ? (5'd31 - rd_round_in) : rd_round_in;
  assign rd_hit_c = ({1'b0, rd_slot_in} < SLOT_LIM) && slot_valid_q[rd_slot_in];

  // Registered read port; invalid or out-of-range slots answer with a miss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      rd_valid_q <= rd_en_in;
      if (rd_en_in) begin
        rd_miss_q <= !rd_hit_c;
        rd_key_q  <= rd_hit_c ? mem_q[rd_slot_in][rd_idx_c] : 32'h0;
      end
    end
  end

  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign done_slot_out  = done_slot_q;
  assign slot_valid_out = slot_valid_q;
  assign rd_valid_out   = rd_valid_q;
  assign rd_miss_out    = rd_miss_q;
  assign rd_key_out     = rd_key_q;

endmodule

// File: tb/tb_sm4_key_sched_multi.sv
// Directed bench for sm4_key_sched_multi: four instances (R = 1, 2, 4, 8)
// share reset/enable/key/read inputs; each has its own key_valid.
module tb_sm4_key_sched_multi;

  localparam int unsigned NI      = 4;
  localparam logic [127:0] STD_KEY = 128'h01234567_89abcdef_fedcba98_76543210;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [NI-1:0] kv;
  logic [127:0] key;
  logic        key_slot;
  logic        rd_en, rd_slot, rd_dec;
  logic [4:0]  rd_round;

  logic        key_ready [NI];
  logic        busy      [NI];
  logic        done      [NI];
  logic        done_slot [NI];
  logic [1:0]  sv        [NI];
  logic        rd_valid  [NI];
  logic        rd_miss   [NI];
  logic [31:0] rd_key    [NI];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  round;
    logic        dec;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [6];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sm4_key_sched_multi #(.ROUNDS_PER_CYCLE(1 << g), .NUM_SLOTS(2)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .enable_in     (enable),
      .key_valid_in  (kv[g]),
      .key_ready_out (key_ready[g]),
      .key_in        (key),
      .key_slot_in   (key_slot),
      .busy_out      (busy[g]),
      .done_out      (done[g]),
      .done_slot_out (done_slot[g]),
      .slot_valid_out(sv[g]),
      .rd_en_in      (rd_en),
      .rd_slot_in    (rd_slot),
      .rd_round_in   (rd_round),
      .rd_decrypt_in (rd_dec),
      .rd_valid_out  (rd_valid[g]),
      .rd_miss_out   (rd_miss[g]),
      .rd_key_out    (rd_key[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic s, input logic [4:0] r, input logic d);
    rd_en    = 1'b1;
    rd_slot  = s;
    rd_round = r;
    rd_dec   = d;
    tick();
    rd_en    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc [NI];
    int pulses;
    int ready_busy;
    int got;

    vecs[0] = '{round: 5'd0,  dec: 1'b0, exp: 32'hF12186F9};
    vecs[1] = '{round: 5'd1,  dec: 1'b0, exp: 32'h41662B61};
    vecs[2] = '{round: 5'd31, dec: 1'b0, exp: 32'h9124A012};
    vecs[3] = '{round: 5'd0,  dec: 1'b1, exp: 32'h9124A012};
    vecs[4] = '{round: 5'd31, dec: 1'b1, exp: 32'hF12186F9};
    vecs[5] = '{round: 5'd30, dec: 1'b1, exp: 32'h41662B61};

    reset = 1'b1; enable = 1'b0; kv = '0; key = '0; key_slot = 1'b0;
    rd_en = 1'b0; rd_slot = 1'b0; rd_round = '0; rd_dec = 1'b0;
    repeat (2) tick();

    // Reset state
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("R%0d_rst_flags", 1 << g),
          {25'b0, busy[g], done[g], done_slot[g], sv[g], rd_valid[g], rd_miss[g]}, 32'h0);
      chk($sformatf("R%0d_rst_key", 1 << g), rd_key[g], 32'h0);
    end
    chk("rst_ready_disabled", {31'b0, key_ready[0]}, 32'h0);
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    chk("ready_idle_enabled", {31'b0, key_ready[0]}, 32'h1);

    // Standard vector into slot 0 on every instance; done latency is 32/R
    key = STD_KEY; key_slot = 1'b0; kv = '1;
    tick();
    kv = '0;
    for (int g = 0; g < NI; g++) begin
      done_cyc[g] = -1;
      chk($sformatf("R%0d_busy_after_accept", 1 << g), {31'b0, busy[g]}, 32'h1);
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        if (done[g] && done_cyc[g] < 0) begin
          done_cyc[g] = cyc;
          chk($sformatf("R%0d_done_slot", 1 << g), {31'b0, done_slot[g]}, 32'h0);
        end
      end
    end
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("R%0d_done_latency", 1 << g), 32'(done_cyc[g]), 32'(32 >> g));
      chk($sformatf("R%0d_slot_valid", 1 << g), {30'b0, sv[g]}, 32'h1);
    end

    // Encrypt and decrypt ordering on slot 0
    foreach (vecs[v]) begin
      do_read(1'b0, vecs[v].round, vecs[v].dec);
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("R%0d_rd_key_r%0d_d%0d", 1 << g, vecs[v].round, vecs[v].dec),
            rd_key[g], vecs[v].exp);
        chk($sformatf("R%0d_rd_flags_r%0d", 1 << g, vecs[v].round),
            {30'b0, rd_valid[g], rd_miss[g]}, 32'h2);
      end
    end
    tick();
    chk("rd_valid_one_cycle", {31'b0, rd_valid[0]}, 32'h0);
    do_read(1'b1, 5'd0, 1'b0);
    chk("rd_empty_slot_flags", {30'b0, rd_valid[0], rd_miss[0]}, 32'h3);
    chk("rd_empty_slot_key", rd_key[0], 32'h0);

    // Back-to-back: slot 0 standard key, slot 1 zero key held pending
    key = STD_KEY; key_slot = 1'b0; kv[0] = 1'b1;
    tick();
    key = '0; key_slot = 1'b1;
    ready_busy = 0;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      tick();
      if (cyc == 1) chk("b2b_rekey_invalidates", {30'b0, sv[0]}, 32'h0);
      if (cyc < 32 && key_ready[0]) ready_busy++;
    end
    chk("b2b_first_done", {31'b0, done[0]}, 32'h1);
    chk("b2b_ready_on_done", {31'b0, key_ready[0]}, 32'h1);
    tick();
    chk("b2b_second_accept", {30'b0, busy[0], done[0]}, 32'h2);
    kv[0] = 1'b0;
    chk("b2b_valid_after_second_accept", {30'b0, sv[0]}, 32'h1);
    chk("b2b_ready_low_while_busy", 32'(ready_busy), 32'h0);
    got = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (done[0] && got < 0) got = cyc;
    end
    chk("b2b_second_latency", 32'(got), 32'd32);
    chk("b2b_slot_valid_both", {30'b0, sv[0]}, 32'h3);
    do_read(1'b0, 5'd0, 1'b0);
    chk("b2b_slot0_round0", rd_key[0], 32'hF12186F9);
    do_read(1'b1, 5'd0, 1'b0);
    chk("b2b_slot1_hit", {30'b0, rd_valid[0], rd_miss[0]}, 32'h2);

    // Abort: drop enable 10 cycles into an expansion of slot 1
    key = STD_KEY; key_slot = 1'b1; kv[0] = 1'b1;
    tick();
    kv[0] = 1'b0;
    chk("abort_slot1_invalidated", {30'b0, sv[0]}, 32'h1);
    repeat (10) tick();
    enable = 1'b0;
    pulses = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (cyc == 1) chk("abort_busy_cleared", {31'b0, busy[0]}, 32'h0);
      if (done[0]) pulses++;
    end
    enable = 1'b1;
    chk("abort_no_done", 32'(pulses), 32'h0);
    chk("abort_slot_valid", {30'b0, sv[0]}, 32'h1);
    do_read(1'b1, 5'd0, 1'b0);
    chk("abort_read_miss_flags", {30'b0, rd_valid[0], rd_miss[0]}, 32'h3);
    chk("abort_read_miss_key", rd_key[0], 32'h0);
    do_read(1'b0, 5'd1, 1'b0);
    chk("abort_slot0_untouched", rd_key[0], 32'h41662B61);

    // Asynchronous reset in the middle of an expansion with a read in flight
    key = STD_KEY; key_slot = 1'b1; kv[0] = 1'b1;
    tick();
    kv[0] = 1'b0;
    repeat (5) tick();
    rd_en = 1'b1; rd_slot = 1'b0; rd_round = 5'd0; rd_dec = 1'b0;
    tick();
    chk("pre_reset_state", {29'b0, busy[0], rd_valid[0], rd_miss[0]}, 32'h6);
    chk("pre_reset_key", rd_key[0], 32'hF12186F9);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_flags",
        {25'b0, busy[0], done[0], done_slot[0], sv[0], rd_valid[0], rd_miss[0]}, 32'h0);
    chk("async_reset_key", rd_key[0], 32'h0);
    rd_en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Back-pressure: key_valid held through the whole expansion
    key = STD_KEY; key_slot = 1'b0; kv[0] = 1'b1;
    tick();
    ready_busy = 0;
    pulses     = 0;
    for (int cyc = 1; cyc <= 75; cyc++) begin
      tick();
      if (busy[0] && key_ready[0]) ready_busy++;
      if (done[0]) pulses++;
      if (cyc == 31) chk("bp_ready_low_busy", {31'b0, key_ready[0]}, 32'h0);
      if (cyc == 32) chk("bp_ready_on_done", {31'b0, key_ready[0]}, 32'h1);
      if (cyc == 33) begin
        chk("bp_second_accept", {31'b0, busy[0]}, 32'h1);
        kv[0] = 1'b0;
      end
    end
    chk("bp_no_ready_while_busy", 32'(ready_busy), 32'h0);
    chk("bp_two_done_pulses", 32'(pulses), 32'd2);
    do_read(1'b0, 5'd31, 1'b0);
    chk("bp_slot0_round31", rd_key[0], 32'h9124A012);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
